// File: rtl/cpu_defines.sv
// Shared controller types: stall vector encodings, redirect offset and FSM states.
package cpu_defines;

    typedef logic [5:0]  Stall_t;
    typedef logic [31:0] Inst_addr_t;

    localparam Stall_t STALL_NONE = 6'b000000;
    localparam Stall_t STALL_IF   = 6'b000011;
    localparam Stall_t STALL_ID   = 6'b000111;
    localparam Stall_t STALL_EX   = 6'b001111;
    localparam Stall_t STALL_MEM  = 6'b011111;

    localparam Inst_addr_t EXCP_OFFSET_DEFAULT = 32'h0000_0180;

    typedef enum logic {
        RUN       = 1'b0,
        EXCP_WAIT = 1'b1
    } ctrl_state_t;

    // The highest-numbered requesting stage freezes itself and everything upstream.
    function automatic Stall_t encode_stall(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
        Stall_t s;
        s = STALL_NONE;
        if (req_mem)     s = STALL_MEM;
        else if (req_ex) s = STALL_EX;
        else if (req_id) s = STALL_ID;
        else if (req_if) s = STALL_IF;
        return s;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stalled cycles; sets a sticky flag once STALL_TIMEOUT is reached.
// Latency: flag rises at the edge that completes the STALL_TIMEOUT-th stalled cycle; no backpressure.
module stall_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_pc,
    input  logic flush,
    output logic stall_timeout
);
    import cpu_defines::*;

    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        run_cnt_d = run_cnt_q;
        timeout_d = timeout_q;
        if (!stall_pc || flush) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
        if (run_cnt_d == CNT_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall arbitration plus exception/ERET redirect, deferred past in-flight MEM accesses.
// Latency: stall/flush/new_pc are combinational (zero cycles); a MEM stall holds a redirect until it clears.
module pipeline_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter logic [31:0] EXCP_OFFSET   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        mem_excp_valid,
    input  logic        mem_excp_is_eret,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] perf_stall_cycles,
    output logic        stall_timeout
);
    import cpu_defines::*;

    ctrl_state_t state_q, state_d;
    Inst_addr_t  excp_pc_q, excp_pc_d;
    Inst_addr_t  new_pc_q, new_pc_d;
    logic [31:0] perf_q, perf_d;

    Stall_t     stall_d;
    logic       flush_d;
    Inst_addr_t target;

    always_comb begin
        state_d   = state_q;
        excp_pc_d = excp_pc_q;
        flush_d   = 1'b0;
        stall_d   = encode_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        target    = mem_excp_is_eret ? cp0_epc : (cp0_ebase + EXCP_OFFSET);
        new_pc_d  = new_pc_q;

        case (state_q)
            RUN: begin
                if (mem_excp_valid) begin
                    if (stallreq_mem) begin
                        excp_pc_d = target;
                        state_d   = EXCP_WAIT;
                        stall_d   = STALL_MEM;
                    end else begin
                        flush_d  = 1'b1;
                        stall_d  = STALL_NONE;
                        new_pc_d = target;
                    end
                end
            end
            EXCP_WAIT: begin
                // The bus access must retire before the pipeline can be torn down.
                if (stallreq_mem) begin
                    stall_d = STALL_MEM;
                end else begin
                    flush_d  = 1'b1;
                    stall_d  = STALL_NONE;
                    new_pc_d = excp_pc_q;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            flush_d  = 1'b0;
            stall_d  = STALL_NONE;
            new_pc_d = new_pc_q;
        end

        perf_d = perf_q;
        if (stall_d[0] && !flush_d && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            excp_pc_q <= '0;
            new_pc_q  <= '0;
            perf_q    <= '0;
        end else begin
            state_q   <= state_d;
            excp_pc_q <= excp_pc_d;
            new_pc_q  <= new_pc_d;
            perf_q    <= perf_d;
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_stall_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_pc      (stall_d[0]),
        .flush         (flush_d),
        .stall_timeout (stall_timeout)
    );

    assign stall             = stall_d;
    assign flush             = flush_d;
    assign new_pc            = new_pc_d;
    assign perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short watchdog timeout.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        mem_excp_valid, mem_excp_is_eret;
    logic [31:0] cp0_epc, cp0_ebase;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] perf_stall_cycles;
    logic        stall_timeout;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(
        .STALL_TIMEOUT (4),
        .EXCP_OFFSET   (32'h0000_0180)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_if       (stallreq_if),
        .stallreq_id       (stallreq_id),
        .stallreq_ex       (stallreq_ex),
        .stallreq_mem      (stallreq_mem),
        .mem_excp_valid    (mem_excp_valid),
        .mem_excp_is_eret  (mem_excp_is_eret),
        .cp0_epc           (cp0_epc),
        .cp0_ebase         (cp0_ebase),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .perf_stall_cycles (perf_stall_cycles),
        .stall_timeout     (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        mem_excp_valid = 0; mem_excp_is_eret = 0;
        cp0_epc = '0; cp0_ebase = '0;
        step();
        step();
        #2;
        chk("rst_stall",   32'(stall), 32'h0);
        chk("rst_flush",   32'(flush), 32'h0);
        chk("rst_new_pc",  new_pc, 32'h0);
        chk("rst_perf",    perf_stall_cycles, 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        rst = 1'b0;
        step();

        // Stall priority
        stallreq_id = 1; stallreq_ex = 1; #2;
        chk("prio_ex_stall", 32'(stall), 32'h0F);
        chk("prio_ex_flush", 32'(flush), 32'h0);
        step();
        stallreq_ex = 0; #2;
        chk("prio_id_stall", 32'(stall), 32'h07);
        step();
        stallreq_id = 0; #2;
        chk("prio_none_stall", 32'(stall), 32'h00);
        step();

        // Immediate exception beats an EX stall
        mem_excp_valid = 1; stallreq_ex = 1; cp0_ebase = 32'h8000_0000; #2;
        chk("excp_flush",  32'(flush), 32'h1);
        chk("excp_new_pc", new_pc, 32'h8000_0180);
        chk("excp_stall",  32'(stall), 32'h0);
        step();

        // ERET
        stallreq_ex = 0; mem_excp_is_eret = 1; cp0_epc = 32'h8000_1234; #2;
        chk("eret_flush",  32'(flush), 32'h1);
        chk("eret_new_pc", new_pc, 32'h8000_1234);
        step();
        mem_excp_valid = 0; mem_excp_is_eret = 0; #2;
        chk("idle_flush",      32'(flush), 32'h0);
        chk("idle_new_pc_hold", new_pc, 32'h8000_1234);
        step();

        // Deferred redirect behind a MEM stall
        mem_excp_valid = 1; stallreq_mem = 1; cp0_ebase = 32'hBFC0_0200; #2;
        chk("defer1_stall", 32'(stall), 32'h1F);
        chk("defer1_flush", 32'(flush), 32'h0);
        step();
        mem_excp_valid = 0; cp0_ebase = 32'h0; stallreq_id = 1; #2;
        chk("defer2_stall", 32'(stall), 32'h1F);
        chk("defer2_flush", 32'(flush), 32'h0);
        step();
        #2;
        chk("defer3_stall", 32'(stall), 32'h1F);
        chk("defer3_flush", 32'(flush), 32'h0);
        step();
        stallreq_mem = 0; #2;
        chk("defer_flush",  32'(flush), 32'h1);
        chk("defer_new_pc", new_pc, 32'hBFC0_0380);
        chk("defer_stall",  32'(stall), 32'h0);
        step();
        stallreq_id = 0; #2;
        chk("defer_after_flush", 32'(flush), 32'h0);
        chk("defer_after_stall", 32'(stall), 32'h0);
        step();

        // Reset while a redirect is pending
        mem_excp_valid = 1; stallreq_mem = 1; cp0_ebase = 32'h8000_0000; #2;
        chk("rstdef_wait_stall", 32'(stall), 32'h1F);
        step();
        mem_excp_valid = 0; rst = 1; #2;
        chk("rstdef_in_rst_flush", 32'(flush), 32'h0);
        step();
        rst = 0; stallreq_mem = 0; #2;
        chk("rstdef_flush",   32'(flush), 32'h0);
        chk("rstdef_stall",   32'(stall), 32'h0);
        chk("rstdef_new_pc",  new_pc, 32'h0);
        chk("rstdef_perf",    perf_stall_cycles, 32'h0);
        chk("rstdef_timeout", 32'(stall_timeout), 32'h0);
        step();
        #2;
        chk("rstdef_flush_later", 32'(flush), 32'h0);

        // A 3-cycle stall stays below the watchdog threshold
        stallreq_if = 1; #2;
        chk("short_stall", 32'(stall), 32'h03);
        step();
        step();
        step();
        stallreq_if = 0; #2;
        chk("short_perf",    perf_stall_cycles, 32'd3);
        chk("short_timeout", 32'(stall_timeout), 32'h0);
        step();
        #2;
        chk("short_timeout_later", 32'(stall_timeout), 32'h0);

        rst = 1;
        step();
        rst = 0;

        // Six stalled cycles trip the watchdog after the fourth
        for (int i = 0; i < 6; i++) begin
            stallreq_if = 1; #2;
            chk($sformatf("long_timeout_%0d", i), 32'(stall_timeout), (i >= 4) ? 32'h1 : 32'h0);
            chk($sformatf("long_perf_%0d", i), perf_stall_cycles, 32'(i));
            step();
        end
        stallreq_if = 0; #2;
        chk("long_perf",    perf_stall_cycles, 32'd6);
        chk("long_timeout", 32'(stall_timeout), 32'h1);
        step();
        step();
        #2;
        chk("long_perf_hold",    perf_stall_cycles, 32'd6);
        chk("long_timeout_hold", 32'(stall_timeout), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline controller. Produces the `stall` vector and the `flush`/`new_pc` pair consumed by every inter-stage register (if_id, id_ex, ex_mem, mem_wb) and by the PC register.
- Arbitrates per-stage stall requests and sequences exception/ERET redirection from the MEM stage.
- Defers any redirect that arrives while a MEM bus access is still in flight.
- Provides a saturating stall-cycle counter and a stall watchdog for debug.

Parameters:
- STALL_TIMEOUT, 1024: consecutive stalled cycles before `stall_timeout` asserts.
- EXCP_OFFSET, 32'h0000_0180: general exception vector offset added to `cp0_ebase`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stallreq_if  in  1  IF stage requests stall (instruction fetch pending)
- stallreq_id  in  1  ID stage requests stall (load-use hazard)
- stallreq_ex  in  1  EX stage requests stall (multi-cycle mul/div)
- stallreq_mem  in  1  MEM stage requests stall (data bus access in flight)
- mem_excp_valid  in  1  instruction in MEM raises an exception
- mem_excp_is_eret  in  1  the MEM exception is an ERET
- cp0_epc  in  32  current EPC (Inst_addr_t)
- cp0_ebase  in  32  current exception base (Inst_addr_t)
- stall  out  6  Stall_t; bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=WB
- flush  out  1  flush all inter-stage registers this cycle
- new_pc  out  32  redirect target, valid only when flush=1
- perf_stall_cycles  out  32  saturating count of cycles with stall[0]=1
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, `rst`=1 at posedge):
  - state=RUN; stall=0; flush=0; new_pc=0; perf_stall_cycles=0; stall_timeout=0.
  - Latched exception registers are cleared.
  - Reset mid-deferral discards the pending exception.
- Stall encoding:
  - Highest-requesting stage wins: mem→6'b011111, ex→6'b001111, id→6'b000111, if→6'b000011, none→0.
  - Consumers insert a bubble where stall[i]=1 and stall[i+1]=0.
- stall and flush are combinational from the current inputs plus registered state (zero added latency).
- States: RUN, EXCP_WAIT.
- RUN:
  - mem_excp_valid=1 and stallreq_mem=0:
    - Same cycle: flush=1, stall=0.
    - new_pc = cp0_epc if mem_excp_is_eret, else cp0_ebase+EXCP_OFFSET (32-bit wrap).
    - Remain in RUN.
  - mem_excp_valid=1 and stallreq_mem=1:
    - Latch the target (computed from inputs this cycle); go to EXCP_WAIT.
    - flush=0; stall=6'b011111.
  - Otherwise flush=0 and stall follows the encoding above.
- EXCP_WAIT:
  - stall=6'b011111 while stallreq_mem=1; mem_excp_valid and all lower-priority requests are ignored.
  - First cycle with stallreq_mem=0: flush=1, new_pc=latched target, stall=0; next state RUN.
- Flush has priority over every stall request in the same cycle.
- new_pc holds its last value when flush=0; it is checked only during flush.
- perf_stall_cycles:
  - +1 on each clk where stall[0]=1 and flush=0.
  - Saturates at 32'hFFFF_FFFF.
- Watchdog:
  - Internal run counter increments while stall[0]=1 and clears to 0 on any cycle with stall[0]=0 or flush=1.
  - When the counter reaches STALL_TIMEOUT, stall_timeout←1 and stays set until rst.
  - The counter saturates; it does not wrap.

Decomposition:
- Shared package (cpu_defines): Stall_t and the constants STALL_NONE/IF/ID/EX/MEM, EXCP_OFFSET default, and a ctrl_state_t enum {RUN, EXCP_WAIT}.
- One natural sub-module: `stall_watchdog` (run counter + sticky flag, parameterised by STALL_TIMEOUT). The perf counter stays inline.

Test Plan:
- Priority: after reset, assert stallreq_id and stallreq_ex together → stall=6'b001111, flush=0. Drop ex → 6'b000111. Drop all → 0.
- Immediate exception: mem_excp_valid=1, eret=0, stallreq_ex=1, cp0_ebase=32'h8000_0000 → same cycle flush=1, new_pc=32'h8000_0180, stall=0.
- ERET: mem_excp_valid=1, mem_excp_is_eret=1, cp0_epc=32'h8000_1234 → flush=1, new_pc=32'h8000_1234.
- Deferred redirect:
  - Exception arrives with stallreq_mem=1 for 3 cycles and cp0_ebase=32'hBFC0_0200 → stall=6'b011111 and flush=0 for those 3 cycles.
  - Change cp0_ebase to 0 during the wait → the latched target is kept.
  - When stallreq_mem drops → flush=1 with new_pc=32'hBFC0_0380. The next cycle is back in RUN with flush=0.
- Reset mid-deferral: enter EXCP_WAIT, assert rst for 1 cycle, then drop stallreq_mem → no flush ever occurs; all outputs are 0.
- Counters: STALL_TIMEOUT=4, hold stallreq_if for 6 cycles → perf_stall_cycles=6. stall_timeout rises after the 4th stalled cycle and stays 1 after the request drops. A 3-cycle stall alone never sets it.
